// File: rtl/sync_fifo_param_if.sv
// Handshake bundle for sync_fifo_param: producer/consumer requests and FIFO status.
// The master modport drives the requests; the slave modport is the FIFO side.
interface sync_fifo_param_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
);
  localparam int AW = $clog2(DEPTH);

  logic             w_en;
  logic [WIDTH-1:0] w_data;
  logic             r_en;
  logic             clr_err;
  logic [WIDTH-1:0] r_data;
  logic             w_full;
  logic             r_empty;
  logic             almost_full;
  logic             almost_empty;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;

  modport master (
    output w_en, w_data, r_en, clr_err,
    input  r_data, w_full, r_empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  w_en, w_data, r_en, clr_err,
    output r_data, w_full, r_empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock register-array FIFO with occupancy count, programmable almost flags,
// optional first-word-fall-through read, and sticky overflow/underflow flags.
module sync_fifo_param #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 64,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4,
  parameter bit FWFT      = 1'b0
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_param_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C   = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_C   = (AW+1)'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      cnt;
  logic [AW:0]      cnt_next;
  logic             full_q;
  logic             empty_q;
  logic             af_q;
  logic             ae_q;
  logic             ovf_q;
  logic             unf_q;
  logic             wr_ok;
  logic             rd_ok;

  // Acceptance uses only registered flags, so there is no w_en/r_en -> flag path.
  assign wr_ok    = bus.w_en & ~full_q;
  assign rd_ok    = bus.r_en & ~empty_q;
  assign cnt_next = cnt + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      cnt     <= cnt_next;
      full_q  <= (cnt_next == FULL_C);
      empty_q <= (cnt_next == '0);
      af_q    <= (cnt_next >= AF_C);
      ae_q    <= (cnt_next <= AE_C);
    end
  end

  // A new error in the same cycle as clr_err must survive the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.w_en && full_q)    ovf_q <= 1'b1;
      else if (bus.clr_err)      ovf_q <= 1'b0;
      if (bus.r_en && empty_q)   unf_q <= 1'b1;
      else if (bus.clr_err)      unf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= bus.w_data;
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is shown directly; forced to zero while empty to keep it deterministic.
      assign bus.r_data = empty_q ? '0 : mem[rd_ptr[AW-1:0]];
    end else begin : g_reg
      logic [WIDTH-1:0] rdata_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)        rdata_q <= '0;
        else if (rd_ok) rdata_q <= mem[rd_ptr[AW-1:0]];
      end
      assign bus.r_data = rdata_q;
    end
  endgenerate

  assign bus.w_full       = full_q;
  assign bus.r_empty      = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = cnt;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: registered-read and FWFT instances share one stimulus
// stream and are compared every cycle against a queue-based reference model.
module tb_sync_fifo_param;
  localparam int WIDTH = 32;
  localparam int DEPTH = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             w_en, r_en, clr_err;
  logic [WIDTH-1:0] w_data;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] rd0;
  bit               ovf, unf;

  sync_fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if0 ();
  sync_fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if1 ();

  assign if0.w_en = w_en;  assign if0.w_data = w_data;
  assign if0.r_en = r_en;  assign if0.clr_err = clr_err;
  assign if1.w_en = w_en;  assign if1.w_data = w_data;
  assign if1.r_en = r_en;  assign if1.clr_err = clr_err;

  sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave));
  sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    rd0 = '0;
    ovf = 1'b0;
    unf = 1'b0;
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    check("count",        64'(if0.count),        64'(n));
    check("r_empty",      64'(if0.r_empty),      64'(n == 0));
    check("w_full",       64'(if0.w_full),       64'(n == DEPTH));
    check("almost_full",  64'(if0.almost_full),  64'(n >= DEPTH - 4));
    check("almost_empty", 64'(if0.almost_empty), 64'(n <= 4));
    check("overflow",     64'(if0.overflow),     64'(ovf));
    check("underflow",    64'(if0.underflow),    64'(unf));
    check("r_data_reg",   64'(if0.r_data),       64'(rd0));
    check("count_fwft",   64'(if1.count),        64'(n));
    check("r_data_fwft",  64'(if1.r_data),       (n > 0) ? 64'(q[0]) : 64'(0));
  endtask

  // Drive one cycle, advance the reference model by the accept rules, then compare.
  task automatic step(input logic we, input logic [WIDTH-1:0] wd, input logic re, input logic ce);
    bit full_b, empty_b;
    w_en = we; w_data = wd; r_en = re; clr_err = ce;
    full_b  = (q.size() == DEPTH);
    empty_b = (q.size() == 0);
    @(posedge clk);
    if (re && !empty_b) rd0 = q.pop_front();
    if (we && !full_b)  q.push_back(wd);
    if (we && full_b) ovf = 1'b1; else if (ce) ovf = 1'b0;
    if (re && empty_b) unf = 1'b1; else if (ce) unf = 1'b0;
    #1;
    w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0;
    check_all();
  endtask

  initial begin
    logic [WIDTH-1:0] nxt;
    rst = 1'b1; w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0; w_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // Reset then idle, underflow on empty read, clear
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);

    // Fill 0x1..0x40, then one rejected write
    for (int i = 1; i <= DEPTH; i++) step(1, WIDTH'(i), 0, 0);
    step(1, 32'hDEAD_BEEF, 0, 0);
    step(0, 0, 0, 1);

    // Drain everything
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0);
    check("drain_last", 64'(if0.r_data), 64'h40);

    // Simultaneous write+read at 0, 32 and 64 entries
    step(1, 32'h1111, 1, 0);
    step(0, 0, 0, 1);
    for (int i = 0; i < 31; i++) step(1, $urandom, 0, 0);
    step(1, 32'h2222, 1, 0);
    check("sim32_count", 64'(if0.count), 64'd32);
    for (int i = 0; i < 32; i++) step(1, $urandom, 0, 0);
    step(1, 32'h3333, 1, 0);
    check("sim64_count", 64'(if0.count), 64'd63);
    step(0, 0, 0, 1);

    // Random interleaving with write-biased then read-biased phases
    for (int i = 0; i < 200; i++) begin
      int pw;
      pw = (i < 100) ? 40 : 70;
      step(($urandom_range(99) >= pw), $urandom, ($urandom_range(99) >= 100 - pw),
           ($urandom_range(99) < 5));
    end
    step(1, 32'hCAFE, 0, 1);

    // Reset mid-burst at 17 entries
    while (q.size() > 0) step(0, 0, 1, 0);
    for (int i = 0; i < 17; i++) step(1, WIDTH'(i + 100), 0, 0);
    w_en = 1'b1; w_data = 32'h77;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    w_en = 1'b0;
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    step(0, 0, 0, 0);
    step(1, 32'hA5, 0, 0);
    nxt = if1.r_data;
    check("a5_fwft", 64'(nxt), 64'hA5);
    step(0, 0, 1, 0);
    check("a5_reg", 64'(if0.r_data), 64'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
